// File: rtl/rename_map_pkg.sv
// rtl/rename_map_pkg.sv - shared sizing defaults and register-index typedefs for the rename map
package rename_map_pkg;

  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;
  localparam int AREG_W_DEF    = $clog2(ARCH_REGS_DEF);
  localparam int PREG_W_DEF    = $clog2(PHYS_REGS_DEF);

  typedef logic [AREG_W_DEF-1:0] areg_t;
  typedef logic [PREG_W_DEF-1:0] preg_t;

endpackage

// File: rtl/rename_map_phys_freelist.sv
// rtl/rename_map_phys_freelist.sv - circular free list with speculative and committed heads
module phys_freelist
  import rename_map_pkg::*;
#(
  parameter int  ARCH_REGS = ARCH_REGS_DEF,
  parameter int  PHYS_REGS = PHYS_REGS_DEF,
  localparam int PREG_W    = $clog2(PHYS_REGS)
)(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pop_i,
  input  logic              push_i,
  input  logic [PREG_W-1:0] push_data_i,
  input  logic              restore_i,
  output logic [PREG_W-1:0] head_data_o,
  output logic [PREG_W:0]   count_o
);

  localparam int INIT_FREE = PHYS_REGS - ARCH_REGS;

  logic [PREG_W-1:0] r_mem [PHYS_REGS];
  logic [PREG_W-1:0] r_head;
  logic [PREG_W-1:0] r_chead;
  logic [PREG_W-1:0] r_tail;
  logic [PREG_W:0]   r_count;
  logic [PREG_W-1:0] w_tail_nxt;
  logic [PREG_W-1:0] w_chead_nxt;

  // A retiring instruction both frees its old mapping and consumes one committed slot.
  always_comb begin
    w_tail_nxt  = r_tail + PREG_W'(push_i);
    w_chead_nxt = r_chead + PREG_W'(push_i);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        r_mem[i] <= (i < INIT_FREE) ? PREG_W'(ARCH_REGS + i) : '0;
      end
      r_head  <= '0;
      r_chead <= '0;
      r_tail  <= PREG_W'(INIT_FREE);
      r_count <= (PREG_W+1)'(INIT_FREE);
    end else begin
      if (push_i) begin
        r_mem[r_tail] <= push_data_i;
      end
      r_tail  <= w_tail_nxt;
      r_chead <= w_chead_nxt;
      if (restore_i) begin
        r_head  <= w_chead_nxt;
        r_count <= {1'b0, w_tail_nxt - w_chead_nxt};
      end else begin
        r_head  <= r_head + PREG_W'(pop_i);
        r_count <= r_count + (PREG_W+1)'(push_i) - (PREG_W+1)'(pop_i);
      end
    end
  end

  assign head_data_o = r_mem[r_head];
  assign count_o     = r_count;

endmodule

// File: rtl/rename_map.sv
// rtl/rename_map.sv - speculative/retirement RATs, busy table and registered rename output
module rename_map
  import rename_map_pkg::*;
#(
  parameter int  ARCH_REGS = ARCH_REGS_DEF,
  parameter int  PHYS_REGS = PHYS_REGS_DEF,
  localparam int AREG_W    = $clog2(ARCH_REGS),
  localparam int PREG_W    = $clog2(PHYS_REGS)
)(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [AREG_W-1:0] rs1_addr_i,
  input  logic [AREG_W-1:0] rs2_addr_i,
  input  logic [AREG_W-1:0] rd_addr_i,
  input  logic              rd_wen_i,
  output logic              out_valid_o,
  output logic [PREG_W-1:0] prs1_addr_o,
  output logic [PREG_W-1:0] prs2_addr_o,
  output logic [PREG_W-1:0] prd_addr_o,
  output logic [PREG_W-1:0] prd_old_addr_o,
  output logic              prs1_valid_o,
  output logic              prs2_valid_o,
  input  logic              cdb_en_i,
  input  logic [PREG_W-1:0] cdb_reg_addr_i,
  input  logic              commit_en_i,
  input  logic [AREG_W-1:0] commit_rd_addr_i,
  input  logic [PREG_W-1:0] commit_prd_i,
  input  logic [PREG_W-1:0] commit_prd_old_i,
  input  logic              flush_i
);

  logic [PREG_W-1:0]    r_srat [ARCH_REGS];
  logic [PREG_W-1:0]    r_rrat [ARCH_REGS];
  logic [PHYS_REGS-1:0] r_busy;

  logic                 w_accept;
  logic                 w_alloc;
  logic                 w_commit;
  logic [PREG_W-1:0]    w_free_head;
  logic [PREG_W:0]      w_free_cnt;
  logic [PREG_W-1:0]    w_prs1;
  logic [PREG_W-1:0]    w_prs2;
  logic                 w_prs1_rdy;
  logic                 w_prs2_rdy;

  phys_freelist #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_REGS (PHYS_REGS)
  ) u_freelist (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .pop_i       (w_alloc),
    .push_i      (w_commit),
    .push_data_i (commit_prd_old_i),
    .restore_i   (flush_i),
    .head_data_o (w_free_head),
    .count_o     (w_free_cnt)
  );

  assign inst_ready_o = reset_i & (w_free_cnt != '0) & ~flush_i;
  assign w_accept     = inst_valid_i & inst_ready_o;
  assign w_alloc      = w_accept & rd_wen_i & (rd_addr_i != '0);
  // A zero old mapping marks a non-allocating instruction, which has nothing to retire.
  assign w_commit     = commit_en_i & (commit_prd_old_i != '0);

  assign w_prs1     = r_srat[rs1_addr_i];
  assign w_prs2     = r_srat[rs2_addr_i];
  assign w_prs1_rdy = ~r_busy[w_prs1] | (cdb_en_i & (cdb_reg_addr_i == w_prs1));
  assign w_prs2_rdy = ~r_busy[w_prs2] | (cdb_en_i & (cdb_reg_addr_i == w_prs2));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_srat[i] <= PREG_W'(i);
        r_rrat[i] <= PREG_W'(i);
      end
    end else begin
      if (w_commit) begin
        r_rrat[commit_rd_addr_i] <= commit_prd_i;
      end
      // Flush restores from the retirement view including this cycle's commit.
      if (flush_i) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          r_srat[i] <= (w_commit && (commit_rd_addr_i == AREG_W'(i))) ? commit_prd_i : r_rrat[i];
        end
      end else if (w_alloc) begin
        r_srat[rd_addr_i] <= w_free_head;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_busy <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
    end else begin
      if (cdb_en_i) begin
        r_busy[cdb_reg_addr_i] <= 1'b0;
      end
      if (w_alloc) begin
        r_busy[w_free_head] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid_o    <= 1'b0;
      prs1_addr_o    <= '0;
      prs2_addr_o    <= '0;
      prd_addr_o     <= '0;
      prd_old_addr_o <= '0;
      prs1_valid_o   <= 1'b0;
      prs2_valid_o   <= 1'b0;
    end else begin
      out_valid_o <= w_accept;
      if (w_accept) begin
        prs1_addr_o    <= w_prs1;
        prs2_addr_o    <= w_prs2;
        prs1_valid_o   <= w_prs1_rdy;
        prs2_valid_o   <= w_prs2_rdy;
        prd_addr_o     <= w_alloc ? w_free_head : '0;
        prd_old_addr_o <= w_alloc ? r_srat[rd_addr_i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// tb/tb_rename_map.sv - randomized and directed checks of rename_map against a queue-based model
module tb_rename_map;
  import rename_map_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  areg_t       rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        rd_wen_i;
  logic        out_valid_o;
  preg_t       prs1_addr_o, prs2_addr_o, prd_addr_o, prd_old_addr_o;
  logic        prs1_valid_o, prs2_valid_o;
  logic        cdb_en_i;
  preg_t       cdb_reg_addr_i;
  logic        commit_en_i;
  areg_t       commit_rd_addr_i;
  preg_t       commit_prd_i, commit_prd_old_i;
  logic        flush_i;

  rename_map dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
    .out_valid_o(out_valid_o), .prs1_addr_o(prs1_addr_o), .prs2_addr_o(prs2_addr_o),
    .prd_addr_o(prd_addr_o), .prd_old_addr_o(prd_old_addr_o),
    .prs1_valid_o(prs1_valid_o), .prs2_valid_o(prs2_valid_o),
    .cdb_en_i(cdb_en_i), .cdb_reg_addr_i(cdb_reg_addr_i),
    .commit_en_i(commit_en_i), .commit_rd_addr_i(commit_rd_addr_i),
    .commit_prd_i(commit_prd_i), .commit_prd_old_i(commit_prd_old_i),
    .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int rd; int prd; int old;} rob_t;

  int   tests = 0;
  int   fails = 0;

  int   m_srat [32];
  int   m_rrat [32];
  bit   m_busy [64];
  int   fl_spec [$];
  int   fl_arch [$];
  rob_t rob [$];

  logic exp_ready, obs_ready, exp_valid, exp_v1, exp_v2;
  logic [5:0] exp_prs1, exp_prs2, exp_prd, exp_old;

  function automatic logic [26:0] obs_vec();
    return {out_valid_o, prs1_addr_o, prs2_addr_o, prd_addr_o, prd_old_addr_o, prs1_valid_o, prs2_valid_o};
  endfunction

  function automatic logic [26:0] exp_vec();
    return {exp_valid, exp_prs1, exp_prs2, exp_prd, exp_old, exp_v1, exp_v2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_srat[i] = i; m_rrat[i] = i; end
    for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
    fl_spec.delete(); fl_arch.delete(); rob.delete();
    for (int p = 32; p < 64; p++) begin fl_spec.push_back(p); fl_arch.push_back(p); end
    {exp_valid, exp_prs1, exp_prs2, exp_prd, exp_old, exp_v1, exp_v2} = '0;
  endtask

  task automatic drive_idle();
    inst_valid_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0; rd_wen_i = 0;
    cdb_en_i = 0; cdb_reg_addr_i = 0; commit_en_i = 0; commit_rd_addr_i = 0;
    commit_prd_i = 0; commit_prd_old_i = 0; flush_i = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 1'b1;
    model_reset();
  endtask

  // Drive one cycle at posedge+1, advance the model, and return at the next posedge+1.
  task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit wen,
                      input bit cdb, input int ca, input bit cm, input int crd, input int cprd,
                      input int cold, input bit fl);
    bit acc;
    int p;
    inst_valid_i = v; rs1_addr_i = rs1[4:0]; rs2_addr_i = rs2[4:0]; rd_addr_i = rd[4:0];
    rd_wen_i = wen; cdb_en_i = cdb; cdb_reg_addr_i = ca[5:0]; commit_en_i = cm;
    commit_rd_addr_i = crd[4:0]; commit_prd_i = cprd[5:0]; commit_prd_old_i = cold[5:0]; flush_i = fl;
    #1;
    obs_ready = inst_ready_o;
    exp_ready = (fl_spec.size() != 0) && !fl;
    acc = v && exp_ready;
    exp_valid = acc;
    if (acc) begin
      exp_prs1 = 6'(m_srat[rs1]);
      exp_prs2 = 6'(m_srat[rs2]);
      exp_v1 = !m_busy[exp_prs1] || (cdb && ca == int'(exp_prs1));
      exp_v2 = !m_busy[exp_prs2] || (cdb && ca == int'(exp_prs2));
      if (wen && rd != 0) begin
        exp_prd = 6'(fl_spec[0]);
        exp_old = 6'(m_srat[rd]);
      end else begin
        exp_prd = 0;
        exp_old = 0;
      end
    end
    if (cdb) m_busy[ca] = 1'b0;
    if (acc && wen && rd != 0) begin
      p = fl_spec.pop_front();
      rob.push_back('{rd, p, m_srat[rd]});
      m_srat[rd] = p;
      m_busy[p] = 1'b1;
    end
    if (cm && cold != 0) begin
      m_rrat[crd] = cprd;
      fl_arch.push_back(cold);
      void'(fl_arch.pop_front());
      fl_spec.push_back(cold);
    end
    if (fl) begin
      m_srat = m_rrat;
      fl_spec = fl_arch;
      for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
      rob.delete();
    end
    @(posedge clk_i); #1;
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    reset_i = 1'b0;
    #3;
    tests++;
    if (obs_vec() !== 27'd0) begin
      fails++; $display("FAIL reset_outputs_during: got %h want 0", obs_vec());
    end
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    model_reset();
    #1;
    tests++;
    if (inst_ready_o !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b want 1", inst_ready_o);
    end
    tests++;
    if (obs_vec() !== 27'd0) begin
      fails++; $display("FAIL reset_outputs_after: got %h want 0", obs_vec());
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs_vec() !== {1'b1, 6'd1, 6'd2, 6'd32, 6'd3, 1'b1, 1'b1}) begin
      fails++; $display("FAIL basic_rename: got %h want %h", obs_vec(), {1'b1, 6'd1, 6'd2, 6'd32, 6'd3, 1'b1, 1'b1});
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs_vec() !== {1'b0, 6'd1, 6'd2, 6'd32, 6'd3, 1'b1, 1'b1}) begin
      fails++; $display("FAIL basic_hold: got %h want %h", obs_vec(), {1'b0, 6'd1, 6'd2, 6'd32, 6'd3, 1'b1, 1'b1});
    end
  endtask

  task automatic test_bypass();
    do_reset();
    step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (prd_addr_o !== 6'd32) begin
      fails++; $display("FAIL bypass_alloc: got %0d want 32", prd_addr_o);
    end
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({prs1_addr_o, prs1_valid_o} !== {6'd32, 1'b0}) begin
      fails++; $display("FAIL bypass_busy: got prs1=%0d v=%b want 32 v=0", prs1_addr_o, prs1_valid_o);
    end
    step(1, 5, 0, 0, 0, 1, 32, 0, 0, 0, 0, 0);
    tests++;
    if ({prs1_addr_o, prs1_valid_o} !== {6'd32, 1'b1}) begin
      fails++; $display("FAIL bypass_cdb: got prs1=%0d v=%b want 32 v=1", prs1_addr_o, prs1_valid_o);
    end
    step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({prs1_valid_o, prs2_valid_o} !== 2'b11) begin
      fails++; $display("FAIL bypass_woken: got %b want 11", {prs1_valid_o, prs2_valid_o});
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, (i % 31) + 1, 1, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (obs_ready !== 1'b1 || prd_addr_o !== 6'(32 + i)) begin
        fails++; $display("FAIL full_fill[%0d]: got ready=%b prd=%0d want 1 %0d", i, obs_ready, prd_addr_o, 32 + i);
      end
    end
    #1;
    tests++;
    if (inst_ready_o !== 1'b0) begin
      fails++; $display("FAIL full_ready_low: got %b want 0", inst_ready_o);
    end
    step(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (out_valid_o !== 1'b0) begin
      fails++; $display("FAIL full_no_accept: got %b want 0", out_valid_o);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32, 1, 0);
    tests++;
    if (inst_ready_o !== 1'b1) begin
      fails++; $display("FAIL full_ready_back: got %b want 1", inst_ready_o);
    end
    step(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (prd_addr_o !== 6'd1) begin
      fails++; $display("FAIL full_realloc: got %0d want 1", prd_addr_o);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({out_valid_o, prd_addr_o, prd_old_addr_o} !== {1'b1, 6'd0, 6'd0}) begin
      fails++; $display("FAIL rd0_noalloc: got v=%b prd=%0d old=%0d want 1 0 0", out_valid_o, prd_addr_o, prd_old_addr_o);
    end
    step(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({prs1_addr_o, prs1_valid_o, prd_addr_o} !== {6'd0, 1'b1, 6'd32}) begin
      fails++; $display("FAIL rd0_after: got prs1=%0d v=%b prd=%0d want 0 1 32", prs1_addr_o, prs1_valid_o, prd_addr_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({prd_addr_o, prd_old_addr_o} !== {6'd33, 6'd32}) begin
      fails++; $display("FAIL flush_second: got prd=%0d old=%0d want 33 32", prd_addr_o, prd_old_addr_o);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 32, 4, 0);
    step(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1);
    tests++;
    if ({obs_ready, out_valid_o} !== 2'b00) begin
      fails++; $display("FAIL flush_blocks: got ready=%b valid=%b want 0 0", obs_ready, out_valid_o);
    end
    step(1, 4, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs_vec() !== {1'b1, 6'd32, 6'd0, 6'd33, 6'd7, 1'b1, 1'b1}) begin
      fails++; $display("FAIL flush_restore: got %h want %h", obs_vec(), {1'b1, 6'd32, 6'd0, 6'd33, 6'd7, 1'b1, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_i = 1'b0;
    #1;
    tests++;
    if (obs_vec() !== 27'd0) begin
      fails++; $display("FAIL async_reset_clear: got %h want 0", obs_vec());
    end
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    model_reset();
    step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({prd_addr_o, prd_old_addr_o} !== {6'd32, 6'd9}) begin
      fails++; $display("FAIL async_reset_realloc: got prd=%0d old=%0d want 32 9", prd_addr_o, prd_old_addr_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit   cm, cdb, fl;
      int   crd, cprd, cold, ca;
      rob_t e;
      cm = 0; crd = 0; cprd = 0; cold = 0;
      if (rob.size() > 0 && $urandom_range(0, 2) == 0) begin
        e = rob.pop_front();
        cm = 1; crd = e.rd; cprd = e.prd; cold = e.old;
      end else if ($urandom_range(0, 15) == 0) begin
        cm = 1; crd = $urandom_range(0, 31); cprd = $urandom_range(0, 63);
      end
      cdb = 1'($urandom_range(0, 1));
      ca  = (rob.size() > 0 && $urandom_range(0, 1) == 1) ? rob[$urandom_range(0, rob.size() - 1)].prd
                                                          : int'($urandom_range(0, 63));
      fl  = ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           1'($urandom_range(0, 1)), cdb, ca, cm, crd, cprd, cold, fl);
      tests++;
      if (obs_ready !== exp_ready) begin
        fails++; $display("FAIL rand_ready[%0d]: got %b want %b", n, obs_ready, exp_ready);
      end
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL rand_out[%0d]: got %h want %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    drive_idle();
    reset_i = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_full();
    test_rd_zero();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
